// File: rtl/even_parity_serial_rx_pkg.sv
// ============================================================================
// Module   : even_parity_serial_rx_pkg
// Purpose  : Shared state encoding and defaults for the even-parity receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package even_parity_serial_rx_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/even_parity_serial_rx_parity_acc.sv
// ============================================================================
// Module   : parity_acc
// Purpose  : 1-bit XOR accumulator; clr restarts the sum from d when en is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    logic r_q;

    // clr with en loads d directly so the first bit of a frame seeds the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (clr) begin
            r_q <= en & d;
        end else if (en) begin
            r_q <= r_q ^ d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/even_parity_serial_rx.sv
// ============================================================================
// Module   : even_parity_serial_rx
// Purpose  : Deserializes DATA_W data bits plus an even-parity bit and checks it.
//            Optional macro PARITY_ERR_CNT_EN adds a saturating err_count port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module even_parity_serial_rx
    import even_parity_serial_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic              din,
    input  logic              din_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int              CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_W - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_data_valid;
    logic                r_parity_err;
    logic                r_frame_err;
    logic                r_busy;

    logic                w_start;
    logic                w_shift;
    logic                w_done;
    logic                w_abort;
    logic                w_acc;
    logic                w_par_calc;

    // sof with a valid bit always restarts a frame, whatever state we are in.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        if (din_valid) begin
            if (sof) begin
                w_start     = 1'b1;
                w_abort     = (r_state != ST_IDLE);
                w_state_nxt = ST_DATA;
            end else begin
                case (r_state)
                    ST_DATA: begin
                        w_shift = 1'b1;
                        if (r_bit_cnt == C_LAST_BIT) begin
                            w_state_nxt = ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    parity_acc u_parity_acc (
        .clk (clk),
        .rst (rst),
        .clr (w_start),
        .en  (w_start | w_shift),
        .d   (din),
        .q   (w_acc)
    );

    assign w_par_calc = w_acc ^ din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_start) begin
            r_bit_cnt <= CNT_W'(1);
            r_shift   <= DATA_W'(din);
        end else if (w_shift) begin
            r_shift[r_bit_cnt] <= din;
            r_bit_cnt          <= (r_bit_cnt == C_LAST_BIT) ? '0 : r_bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_valid <= w_done;
            r_frame_err  <= w_abort;
            r_busy       <= (w_state_nxt != ST_IDLE);
            if (w_done) begin
                r_data_out   <= r_shift;
                r_parity_err <= w_par_calc;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= 8'd0;
        end else if (w_done && w_par_calc && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_even_parity_serial_rx.sv
// ============================================================================
// Module   : tb_even_parity_serial_rx
// Purpose  : Directed self-checking bench for even_parity_serial_rx (DATA_W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_even_parity_serial_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sof;
    logic       din;
    logic       din_valid;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
`ifdef PARITY_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_dv  = 0;
    int n_fe  = 0;
    int cyc   = 0;

    even_parity_serial_rx #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .din        (din),
        .din_valid  (din_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (data_valid) n_dv++;
        if (frame_err)  n_fe++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic s, input logic d);
        sof       = s;
        din       = d;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sof       = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends all eight data bits and the parity bit; gap_at < 0 means no gap.
    task automatic send_frame(input string tag, input logic [7:0] data, input logic p,
                              input logic exp_perr, input int gap_at);
        for (int i = 0; i < 8; i++) begin
            send_bit(i == 0, data[i]);
            if (i == gap_at) begin
                idle(3);
                check({tag, "_gap_busy"}, busy, 1'b1);
                check({tag, "_gap_dv"}, data_valid, 1'b0);
                din_valid = 1'b1;
            end
        end
        check({tag, "_pre_dv"}, data_valid, 1'b0);
        send_bit(1'b0, p);
        check({tag, "_dv"}, data_valid, 1'b1);
        check({tag, "_data"}, data_out, data);
        check({tag, "_perr"}, parity_err, exp_perr);
    endtask

    int dv0;
    int fe0;
    int t1;

    initial begin
        rst = 1'b1; sof = 1'b0; din = 1'b0; din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_out, 8'h00);
        check("rst_dv", data_valid, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(1);

        // Reset mid-frame
        dv0 = n_dv; fe0 = n_fe;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        check("mid_busy", busy, 1'b1);
        din_valid = 1'b0; sof = 1'b0;
        rst = 1'b1;
        #2;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_dv", data_valid, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(1);
        check("mid_rst_no_dv", n_dv - dv0, 0);
        check("mid_rst_no_fe", n_fe - fe0, 0);
        send_frame("a5", 8'hA5, 1'b0, 1'b0, -1);
        idle(1);

        // Good frame; pulse lasts one cycle and data_out holds
        send_frame("0f", 8'h0F, 1'b0, 1'b0, -1);
        idle(1);
        check("0f_dv_drop", data_valid, 1'b0);
        check("0f_hold", data_out, 8'h0F);
        check("0f_busy", busy, 1'b0);

        // Bad parity
        send_frame("01", 8'h01, 1'b0, 1'b1, -1);
`ifdef PARITY_ERR_CNT_EN
        check("01_errcnt", err_count, 8'd1);
`endif
        idle(2);

        // Gaps between bits 2 and 3
        send_frame("3c", 8'h3C, 1'b0, 1'b0, 2);
        idle(2);

        // Abort after 5 bits, then 0xFF
        dv0 = n_dv; fe0 = n_fe;
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        check("abort_fe", frame_err, 1'b1);
        for (int i = 1; i < 8; i++) begin
            send_bit(1'b0, 1'b1);
            if (i == 1) check("abort_fe_drop", frame_err, 1'b0);
        end
        send_bit(1'b0, 1'b0);
        check("abort_dv", data_valid, 1'b1);
        check("abort_data", data_out, 8'hFF);
        check("abort_perr", parity_err, 1'b0);
        idle(2);
        check("abort_dv_cnt", n_dv - dv0, 1);
        check("abort_fe_cnt", n_fe - fe0, 1);

        // Back-to-back frames
        for (int i = 0; i < 8; i++) send_bit(i == 0, (8'h12 >> i) & 1);
        send_bit(1'b0, 1'b0);
        check("b2b1_dv", data_valid, 1'b1);
        check("b2b1_data", data_out, 8'h12);
        check("b2b1_perr", parity_err, 1'b0);
        t1 = cyc;
        for (int i = 0; i < 8; i++) begin
            send_bit(i == 0, (8'h13 >> i) & 1);
            if (i == 0) check("b2b_dv_pulse", data_valid, 1'b0);
        end
        send_bit(1'b0, 1'b1);
        check("b2b2_dv", data_valid, 1'b1);
        check("b2b2_data", data_out, 8'h13);
        check("b2b2_perr", parity_err, 1'b0);
        check("b2b_spacing", cyc - t1, 9);
        idle(2);
`ifdef PARITY_ERR_CNT_EN
        check("final_errcnt", err_count, 8'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
